// File: rtl/track_occupancy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : track_occupancy                                                 |
// | Brief    : Track-section occupancy detector. Synchronises and debounces    |
// |            the approach/exit axle sensors, counts trains in the section    |
// |            and latches a fail-safe fault on inconsistencies or timeouts.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module track_occupancy #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int TMR_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_in,
  input  logic             sensor_out,
  input  logic             clear_fault,
  output logic             train_detect,
  output logic [CNT_W-1:0] occupancy,
  output logic             fault
);

  // Counters compare against "last" values so the update fires on the edge
  // where the count would reach the limit.
  localparam logic [TMR_W-1:0] c_DEB_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_OCC_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_OCC_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_CLEAR    = 2'd0,
    ST_OCCUPIED = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  // Bit 0 is the approach-end sensor, bit 1 the exit-end sensor.
  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic [1:0] w_rise;

  assign w_raw = {sensor_out, sensor_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
      logic             r_s1;
      logic             r_s2;
      logic             r_f;
      logic             r_f_d;
      logic [TMR_W-1:0] r_cnt;

      // Two-flop synchroniser for the asynchronous raw sensor.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_s1 <= 1'b0;
          r_s2 <= 1'b0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
        end
      end

      // Debounce: accept a new level only after it has held long enough;
      // any return to the filtered level restarts the count.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
          r_f   <= 1'b0;
          r_f_d <= 1'b0;
        end else begin
          r_f_d <= r_f;
          if (r_s2 == r_f) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_f   <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_filt[gi] = r_f;
      assign w_rise[gi] = r_f & ~r_f_d;
    end
  endgenerate

  logic w_entry;
  logic w_exit;

  assign w_entry = w_rise[0];
  assign w_exit  = w_rise[1];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_occ_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;

  // Next-state, next-count and timeout-timer logic. The timer defaults to
  // zero so it is cleared by any event and in CLEAR/FAULT.
  always_comb begin
    w_state_nxt = r_state;
    w_occ_nxt   = occupancy;
    w_timer_nxt = '0;
    case (r_state)
      ST_CLEAR: begin
        if (w_entry && !w_exit) begin
          w_state_nxt = ST_OCCUPIED;
          w_occ_nxt   = c_OCC_ONE;
        end else if (w_exit && !w_entry) begin
          // Exit with an empty section: counts can no longer be trusted.
          w_state_nxt = ST_FAULT;
        end
      end
      ST_OCCUPIED: begin
        if (w_entry && w_exit) begin
          // One in, one out: count unchanged, timer restarts.
          w_occ_nxt = occupancy;
        end else if (w_entry) begin
          if (occupancy == c_OCC_MAX) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_occ_nxt = occupancy + 1'b1;
          end
        end else if (w_exit) begin
          w_occ_nxt = occupancy - 1'b1;
          if (occupancy == c_OCC_ONE) begin
            w_state_nxt = ST_CLEAR;
          end
        end else if (r_timer == c_TMO_LAST) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_FAULT: begin
        // Only release once both filtered sensors show the section quiet.
        if (clear_fault && !w_filt[0] && !w_filt[1]) begin
          w_state_nxt = ST_CLEAR;
          w_occ_nxt   = '0;
        end
      end
      default: begin
        // Unreachable encoding: fall to the safe state with the gate down.
        w_state_nxt = ST_FAULT;
      end
    endcase
  end

  // State, count, timer and registered outputs all update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_CLEAR;
      occupancy    <= '0;
      r_timer      <= '0;
      train_detect <= 1'b0;
      fault        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      occupancy    <= w_occ_nxt;
      r_timer      <= w_timer_nxt;
      train_detect <= (w_occ_nxt != '0) || (w_state_nxt == ST_FAULT);
      fault        <= (w_state_nxt == ST_FAULT);
    end
  end

endmodule
`default_nettype wire
